// File: rtl/gemm_stream_controller_pkg.sv
// Shared types and helpers for the GEMM stream controller.
package gemm_stream_controller_pkg;

  typedef enum logic {
    STREAM = 1'b0,
    FLUSH  = 1'b1
  } gemm_ctrl_state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } gemm_tag_t;

  function automatic int gemm_latency(input int sa_size);
    return 2 * sa_size;
  endfunction

endpackage

// File: rtl/gemm_stream_controller_if.sv
// Upstream activation stream and downstream result stream of the controller.
interface gemm_stream_controller_if #(
  parameter int ROW_W = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [ROW_W-1:0] in_row;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ROW_W-1:0] out_row;
  logic             out_last;

  modport master (
    output in_valid, in_row, in_last, out_ready,
    input  in_ready, out_valid, out_row, out_last
  );

  modport slave (
    input  in_valid, in_row, in_last, out_ready,
    output in_ready, out_valid, out_row, out_last
  );
endinterface

// File: rtl/gemm_stream_controller_result_fifo.sv
// Synchronous FIFO with combinational read data; a write into a full FIFO is
// taken only when a read happens in the same cycle.
module gemm_stream_controller_result_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_fire, rd_fire;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign rd_fire   = rd_en_i && !empty_o;
  assign wr_fire   = wr_en_i && (!full_o || rd_fire);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/gemm_stream_controller.sv
// Host-side GEMM stream controller: feeds activation rows into the array,
// flushes it after the last row of a matrix and buffers the result rows.
//
// state  | meaning
// STREAM | accepting upstream rows, one advance per accepted row
// FLUSH  | injecting zero rows until every real row has reached the head
module gemm_stream_controller
  import gemm_stream_controller_pkg::*;
#(
  parameter int SA_SIZE                = 4,
  parameter int WEIGHT_ACTIVATION_SIZE = 8,
  parameter int LATENCY                = gemm_latency(SA_SIZE),
  parameter int OUT_DEPTH              = 4
) (
  input  logic                                      clk,
  input  logic                                      resetn,
  gemm_stream_controller_if.slave                   strm,
  output logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] gemm_activation_inputs,
  input  logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] gemm_activation_outputs,
  output logic                                      gemm_should_advance,
  input  logic                                      gemm_output_valid,
  output logic                                      err
);
  localparam int ROW_W = SA_SIZE * WEIGHT_ACTIVATION_SIZE;
  localparam int IW    = $clog2(LATENCY + 1);
  localparam int CW    = $clog2(OUT_DEPTH) + 1;

  gemm_ctrl_state_t state_q;
  gemm_tag_t        tags_q [LATENCY];
  logic [IW-1:0]    inflight_q, inflight_d;
  logic             cap_q, cap_last_q, err_q;
  logic             adv, push_real, head_arrives;
  logic             fifo_full, fifo_empty, fifo_full_eff, fifo_rd;
  logic [CW-1:0]    fifo_count;
  logic [ROW_W:0]   fifo_rd_data;

  // A capture scheduled by last cycle's advance already owns a FIFO slot.
  assign fifo_full_eff = fifo_full || (cap_q && fifo_count == CW'(OUT_DEPTH - 1));

  always_comb begin
    strm.in_ready          = 1'b0;
    adv                    = 1'b0;
    gemm_activation_inputs = '0;
    if (resetn) begin
      case (state_q)
        STREAM: begin
          strm.in_ready = !fifo_full_eff;
          adv           = strm.in_valid && !fifo_full_eff;
          if (adv) gemm_activation_inputs = strm.in_row;
        end
        FLUSH:   adv = !fifo_full_eff && (inflight_q != '0);
        default: adv = 1'b0;
      endcase
    end
  end

  assign gemm_should_advance = adv;
  assign push_real           = adv && (state_q == STREAM);
  // inflight counts real rows that still need advances to reach the head.
  assign head_arrives        = adv && tags_q[LATENCY-2].valid;

  always_comb begin
    inflight_d = inflight_q;
    if (push_real && !head_arrives)      inflight_d = inflight_q + 1'b1;
    else if (!push_real && head_arrives) inflight_d = inflight_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= STREAM;
      inflight_q <= '0;
      cap_q      <= 1'b0;
      cap_last_q <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < LATENCY; i++) tags_q[i] <= '0;
    end else begin
      inflight_q <= inflight_d;
      cap_q      <= head_arrives;
      cap_last_q <= tags_q[LATENCY-2].last;
      if (cap_q && !gemm_output_valid) err_q <= 1'b1;
      if (adv) begin
        for (int i = LATENCY - 1; i > 0; i--) tags_q[i] <= tags_q[i-1];
        tags_q[0] <= push_real ? gemm_tag_t'{valid: 1'b1, last: strm.in_last} : gemm_tag_t'('0);
      end
      case (state_q)
        STREAM:  if (push_real && strm.in_last) state_q <= FLUSH;
        FLUSH:   if (inflight_q == '0) state_q <= STREAM;
        default: state_q <= STREAM;
      endcase
    end
  end

  assign err = err_q;

  gemm_stream_controller_result_fifo #(
    .WIDTH(ROW_W + 1),
    .DEPTH(OUT_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en_i   (cap_q),
    .wr_data_i ({cap_last_q, gemm_activation_outputs}),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign strm.out_valid = !fifo_empty;
  assign fifo_rd        = strm.out_valid && strm.out_ready;
  assign strm.out_row   = fifo_empty ? '0 : fifo_rd_data[ROW_W-1:0];
  assign strm.out_last  = !fifo_empty && fifo_rd_data[ROW_W];
endmodule

// File: tb/tb_gemm_stream_controller.sv
// Directed bench for gemm_stream_controller with a behavioural GEMM delay line
// (a row pushed on one advance appears at the outputs after 2*SA_SIZE advances).
module tb_gemm_stream_controller;
  localparam int SA    = 4;
  localparam int WA    = 8;
  localparam int DEPTH = 4;
  localparam int LAT   = 2 * SA;
  localparam int ROW_W = SA * WA;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [ROW_W-1:0] act_in, act_out;
  logic             adv, ov, err;
  int               checks = 0, errors = 0, adv_cnt = 0;
  logic [ROW_W:0]   got_q[$];
  logic [ROW_W-1:0] gemm_pipe [LAT];

  gemm_stream_controller_if #(.ROW_W(ROW_W)) strm ();

  gemm_stream_controller #(
    .SA_SIZE(SA), .WEIGHT_ACTIVATION_SIZE(WA), .OUT_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn), .strm(strm),
    .gemm_activation_inputs(act_in), .gemm_activation_outputs(act_out),
    .gemm_should_advance(adv), .gemm_output_valid(ov), .err(err)
  );

  always #5 clk = ~clk;

  assign act_out = gemm_pipe[LAT-1];
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < LAT; i++) gemm_pipe[i] <= '0;
    end else if (adv) begin
      gemm_pipe[0] <= act_in;
      for (int i = 1; i < LAT; i++) gemm_pipe[i] <= gemm_pipe[i-1];
    end
  end

  always @(posedge clk) begin
    if (resetn) begin
      if (adv) adv_cnt++;
      if (strm.out_valid && strm.out_ready) got_q.push_back({strm.out_last, strm.out_row});
    end
  end

  function automatic logic [ROW_W-1:0] mk_row(input int b);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < SA; i++) r[i*WA +: WA] = WA'(b + i);
    return r;
  endfunction

  task automatic push_row(input logic [ROW_W-1:0] row, input logic last, output int waited);
    strm.in_valid = 1'b1; strm.in_row = row; strm.in_last = last; waited = 0;
    while (!strm.in_ready && waited < 200) begin @(negedge clk); waited++; end
    if (!strm.in_ready) begin
      checks++; errors++;
      $display("FAIL push_row_timeout: in_ready=%b after %0d cycles, required 1", strm.in_ready, waited);
    end
    @(negedge clk);
    strm.in_valid = 1'b0; strm.in_last = 1'b0; strm.in_row = '0;
  endtask

  task automatic wait_results(input int n, output bit ok);
    int k = 0;
    while (got_q.size() < n && k < 400) begin @(negedge clk); k++; end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (strm.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", strm.in_ready); end
    checks++; if (adv !== 1'b0) begin errors++; $display("FAIL reset_advance: got %b, required 0", adv); end
    checks++; if (act_in !== '0) begin errors++; $display("FAIL reset_act_in: got %h, required 0", act_in); end
    checks++; if (strm.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", strm.out_valid); end
    checks++; if (strm.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b, required 0", strm.out_last); end
    checks++; if (strm.out_row !== '0) begin errors++; $display("FAIL reset_out_row: got %h, required 0", strm.out_row); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err); end
    resetn = 1'b1;
    @(negedge clk);
    checks++; if (strm.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b, required 1", strm.in_ready); end
  endtask

  task automatic test_single_row();
    int a0, waited;
    got_q.delete(); a0 = adv_cnt;
    push_row(mk_row(1), 1'b1, waited);
    repeat (LAT - 1) @(negedge clk);
    checks++; if (adv_cnt - a0 != LAT) begin errors++; $display("FAIL single_adv_count: got %0d, required %0d", adv_cnt - a0, LAT); end
    checks++; if (adv !== 1'b0) begin errors++; $display("FAIL single_no_extra_adv: got %b, required 0", adv); end
    checks++; if (strm.out_valid !== 1'b0) begin errors++; $display("FAIL single_out_valid_early: got %b, required 0", strm.out_valid); end
    checks++; if (strm.in_ready !== 1'b0) begin errors++; $display("FAIL single_flush_in_ready: got %b, required 0", strm.in_ready); end
    @(negedge clk);
    checks++; if (strm.out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid: got %b, required 1", strm.out_valid); end
    checks++; if (strm.out_last !== 1'b1) begin errors++; $display("FAIL single_out_last: got %b, required 1", strm.out_last); end
    checks++; if (strm.out_row !== mk_row(1)) begin errors++; $display("FAIL single_out_row: got %h, required %h", strm.out_row, mk_row(1)); end
    checks++; if (strm.in_ready !== 1'b1) begin errors++; $display("FAIL single_back_to_stream: got %b, required 1", strm.in_ready); end
    @(negedge clk);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_result_count: got %0d, required 1", got_q.size()); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b, required 0", err); end
  endtask

  task automatic test_back_to_back();
    logic [ROW_W:0] exp_q[$];
    int waited, n;
    bit ok;
    got_q.delete();
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < 4; r++) begin
        push_row(mk_row(16 * (m + 1) + 4 * r), logic'(r == 3), waited);
        exp_q.push_back({logic'(r == 3), mk_row(16 * (m + 1) + 4 * r)});
        if (m == 1 && r == 0) begin
          checks++; if (waited != LAT) begin errors++; $display("FAIL b2b_flush1_stall: got %0d cycles, required %0d", waited, LAT); end
        end
      end
    end
    n = 0;
    while (!strm.in_ready && n < 200) begin @(negedge clk); n++; end
    checks++; if (n != LAT) begin errors++; $display("FAIL b2b_flush2_stall: got %0d cycles, required %0d", n, LAT); end
    wait_results(8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got %0d results, required 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_result_%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    int a0, waited;
    bit ok;
    got_q.delete(); a0 = adv_cnt;
    strm.out_ready = 1'b0;
    for (int r = 0; r < 6; r++) push_row(mk_row(64 + 4 * r), logic'(r == 5), waited);
    repeat (30) @(negedge clk);
    checks++; if (adv_cnt - a0 != LAT + DEPTH - 1) begin errors++; $display("FAIL bp_adv_count: got %0d, required %0d", adv_cnt - a0, LAT + DEPTH - 1); end
    checks++; if (adv !== 1'b0) begin errors++; $display("FAIL bp_adv_stalled: got %b, required 0", adv); end
    checks++; if (strm.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, required 0", strm.in_ready); end
    checks++; if (strm.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b, required 1", strm.out_valid); end
    checks++; if (strm.out_row !== mk_row(64)) begin errors++; $display("FAIL bp_out_row_held: got %h, required %h", strm.out_row, mk_row(64)); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL bp_no_pop: got %0d, required 0", got_q.size()); end
    strm.out_ready = 1'b1;
    wait_results(6, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got %0d results, required 6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== {logic'(i == 5), mk_row(64 + 4 * i)}) begin
        errors++; $display("FAIL bp_result_%0d: got %h, required %h", i, got_q[i], {logic'(i == 5), mk_row(64 + 4 * i)});
      end
    end
    checks++; if (adv_cnt - a0 != 6 + LAT - 1) begin errors++; $display("FAIL bp_total_adv: got %0d, required %0d", adv_cnt - a0, 6 + LAT - 1); end
  endtask

  task automatic test_bubbles();
    int a0, waited;
    bit ok;
    got_q.delete(); a0 = adv_cnt;
    for (int r = 0; r < 4; r++) begin
      push_row(mk_row(16 + 4 * r), logic'(r == 3), waited);
      @(negedge clk);
    end
    wait_results(4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bubble_timeout: got %0d results, required 4", got_q.size()); end
    checks++; if (adv_cnt - a0 != 4 + LAT - 1) begin errors++; $display("FAIL bubble_adv_count: got %0d, required %0d", adv_cnt - a0, 4 + LAT - 1); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== {logic'(i == 3), mk_row(16 + 4 * i)}) begin
        errors++; $display("FAIL bubble_result_%0d: got %h, required %h", i, got_q[i], {logic'(i == 3), mk_row(16 + 4 * i)});
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    int a0, waited;
    got_q.delete();
    for (int r = 0; r < 3; r++) push_row(mk_row(100 + 4 * r), logic'(r == 2), waited);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checks++; if (strm.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b, required 0", strm.in_ready); end
    checks++; if (adv !== 1'b0) begin errors++; $display("FAIL midrst_advance: got %b, required 0", adv); end
    checks++; if (act_in !== '0) begin errors++; $display("FAIL midrst_act_in: got %h, required 0", act_in); end
    checks++; if (strm.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b, required 0", strm.out_valid); end
    checks++; if (strm.out_row !== '0) begin errors++; $display("FAIL midrst_out_row: got %h, required 0", strm.out_row); end
    resetn = 1'b1;
    a0 = adv_cnt;
    repeat (30) @(negedge clk);
    checks++; if (adv_cnt != a0) begin errors++; $display("FAIL midrst_adv_after: got %0d, required 0", adv_cnt - a0); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL midrst_results: got %0d, required 0", got_q.size()); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b, required 0", err); end
    checks++; if (strm.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready_after: got %b, required 1", strm.in_ready); end
  endtask

  task automatic test_error();
    int waited;
    bit ok;
    got_q.delete();
    ov = 1'b0;
    push_row(mk_row(1), 1'b1, waited);
    repeat (LAT - 1) @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_before_capture: got %b, required 0", err); end
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b, required 1", err); end
    ov = 1'b1;
    push_row(mk_row(5), 1'b1, waited);
    wait_results(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL err_timeout: got %0d results, required 2", got_q.size()); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b, required 1", err); end
    resetn = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared_by_reset: got %b, required 0", err); end
    resetn = 1'b1;
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_after_release: got %b, required 0", err); end
  endtask

  initial begin
    strm.in_valid = 1'b0; strm.in_row = '0; strm.in_last = 1'b0;
    strm.out_ready = 1'b1; ov = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_row();
    test_back_to_back();
    test_backpressure();
    test_bubbles();
    test_reset_mid_flush();
    test_error();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end
endmodule

// File: doc/gemm_stream_controller.md
Name: gemm_stream_controller

Overview:
- Host-side controller for the GEMM core.
- Accepts activation rows from an upstream valid/ready stream and drives them into GEMM, one row per advance.
- Tracks which GEMM output rows are real results, flushes the pipeline with zero rows after the last row of a matrix, and delivers result rows on a downstream valid/ready stream.
- Sits between the activation buffer and the result buffer, wrapping the GEMM instance's activation and advance pins.

Parameters:
- SA_SIZE, 4, systolic array dimension; lanes per row.
- WEIGHT_ACTIVATION_SIZE, 8, bits per lane.
- LATENCY, 2*SA_SIZE, advances from a row's push to its result appearing at the GEMM outputs.
- OUT_DEPTH, 4, result FIFO depth in rows; power of two, ≥2.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset; also drives the GEMM instance.
- in_valid  in  1  upstream row valid.
- in_ready  out  1  upstream row accepted when in_valid && in_ready.
- in_row  in  SA_SIZE x WEIGHT_ACTIVATION_SIZE  activation row.
- in_last  in  1  final row of the current matrix.
- gemm_activation_inputs  out  SA_SIZE x WEIGHT_ACTIVATION_SIZE  to GEMM activation_inputs.
- gemm_activation_outputs  in  SA_SIZE x WEIGHT_ACTIVATION_SIZE  from GEMM activation_outputs.
- gemm_should_advance  out  1  to GEMM should_advance_computation.
- gemm_output_valid  in  1  from GEMM output_valid.
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accept.
- out_row  out  SA_SIZE x WEIGHT_ACTIVATION_SIZE  result row.
- out_last  out  1  result row corresponding to in_last.
- err  out  1  sticky protocol error.

Behaviour:
- **Reset:** all synchronous to clk while resetn=0.
  - in_ready=0, gemm_should_advance=0, gemm_activation_inputs=0, out_valid=0, out_last=0, out_row=0, err=0.
  - FIFO empty, tag pipeline cleared, inflight=0, state=STREAM.
- **Reset mid-operation:** discards all in-flight rows and FIFO contents. No partial results are emitted after reset release.
- **States:**
  - STREAM: accepting input.
  - FLUSH: injecting zero rows until every real row has emerged.
- **STREAM:**
  - in_ready = !fifo_full (combinational).
  - adv = in_valid && in_ready.
  - gemm_activation_inputs = in_row when adv, else 0.
  - gemm_should_advance = adv.
- **Transition STREAM→FLUSH:** on an advance with in_last=1.
- **FLUSH:**
  - in_ready=0.
  - adv = !fifo_full && inflight!=0.
  - gemm_activation_inputs=0.
  - When inflight==0, go to STREAM; a new matrix may start on the following cycle.
- **Tag pipeline:** LATENCY entries of {valid,last}, shifting only on adv.
  - Entry 0 loads {1,in_last} for a real row and {0,0} for a flush row.
  - Head = entry LATENCY-1 after the shift.
- **Capture:** in the cycle after an adv whose shifted head is valid, gemm_activation_outputs is written to the FIFO with head.last.
- **FIFO space:** guaranteed because adv requires !fifo_full. The full flag counts the pending capture as occupied.
- **inflight counter:**
  - +1 on a real push, -1 on a valid head capture; both on the same cycle → unchanged.
  - Range 0..LATENCY.
- **Stall:** no adv in STREAM while in_valid=0. Partial matrices stay in flight until more rows or in_last arrive.
- **err:** set sticky if a valid head is captured while gemm_output_valid=0. Cleared only by reset.
- **Downstream:**
  - out_valid = !fifo_empty; pop on out_valid && out_ready.
  - Push and pop in the same cycle are allowed when the FIFO is full.
  - out_row and out_last are held stable while out_valid && !out_ready.
- **Ordering:** results are emitted in input order with no gaps or duplicates.

Decomposition:
- GEMM_pkg additions:
  - gemm_ctrl_state_t enum {STREAM, FLUSH}.
  - gemm_tag_t struct {valid,last}.
  - Function gemm_latency(sa_size) returning 2*sa_size.
- Sub-module: result_fifo (parameterised width/depth synchronous FIFO with full/empty and combinational read data), instantiated once.

Test Plan:
- **Single row:** one row {1,2,3,4} with in_last=1, out_ready=1.
  - 1 STREAM advance + LATENCY-1=7 flush advances.
  - out_valid rises 1 cycle after the 8th advance with out_last=1; then state=STREAM, inflight=0.
- **Back-to-back matrices:** two 4-row matrices back-to-back.
  - 8 results, in order; out_last on results 4 and 8.
  - in_ready=0 during each FLUSH.
- **Backpressure:** out_ready=0 throughout a 6-row matrix with OUT_DEPTH=4.
  - Exactly 4 results buffered, gemm_should_advance stays 0 thereafter.
  - Releasing out_ready drains all 6 with no loss.
- **Input bubbles:** in_valid toggling 1/0 every cycle.
  - Advances occur only on accepted rows; results unchanged versus the gap-free run.
- **Reset mid-flush:** resetn=0 for 1 cycle with 3 rows in flight.
  - All outputs return to reset values; no results emitted after release; err=0.
- **Error injection:** force gemm_output_valid=0 at the first valid head capture → err=1 and stays 1 until reset.
